// File: rtl/vga_fb_pkg.sv
// Shared types and widths for the VGA framebuffer arbiter.
// Pixel addresses are {row[5:0], col[6:0]} regardless of the visible size.
package vga_fb_pkg;

  localparam int COL_W  = 7;
  localparam int ROW_W  = 6;
  localparam int ADDR_W = ROW_W + COL_W;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } fb_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fb_state_t;

  // True when the pixel lies inside the visible window.
  function automatic logic in_view(input fb_addr_t a,
                                   input logic [COL_W-1:0] cols,
                                   input logic [ROW_W-1:0] rows);
    return (a.col < cols) && (a.row < rows);
  endfunction

endpackage

// File: rtl/vga_fb_fill_gen.sv
// Rectangle-fill address generator: walks the rectangle row-major,
// column wrapping back to the left bound at the end of each row.
// Bounds are captured on load so the command inputs may change afterwards.
module vga_fb_fill_gen
  import vga_fb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [COL_W-1:0] x0,
  input  logic [COL_W-1:0] x1,
  input  logic [ROW_W-1:0] y0,
  input  logic [ROW_W-1:0] y1,
  output fb_addr_t         addr,
  output logic             last
);

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] x0_q;
  logic [COL_W-1:0] x1_q;
  logic [ROW_W-1:0] y1_q;

  // Counter update: load the top-left corner, then advance one pixel per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      x0_q  <= '0;
      x1_q  <= '0;
      y1_q  <= '0;
    end else if (load) begin
      col_q <= x0;
      row_q <= y0;
      x0_q  <= x0;
      x1_q  <= x1;
      y1_q  <= y1;
    end else if (step) begin
      if (col_q == x1_q) begin
        col_q <= x0_q;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign addr = {row_q, col_q};
  assign last = (col_q == x1_q) && (row_q == y1_q);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port-A arbiter between a CPU pixel port and a rectangle-fill
// engine. The fill engine is built only when VGA_FB_FILL_EN is defined;
// otherwise the FILL_* inputs are ignored and the CPU owns the port.
//
//   state | meaning
//   IDLE  | no fill running; FILL_START is sampled here
//   FILL  | fill running; one pixel per cycle the CPU does not take
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic              CLK_50MHz,
  input  logic              RST_N,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [7:0]        CPU_WD,
  output logic [7:0]        CPU_RD,
  output logic              CPU_ACK,
  input  logic              FILL_START,
  input  logic [COL_W-1:0]  FILL_X0,
  input  logic [COL_W-1:0]  FILL_X1,
  input  logic [ROW_W-1:0]  FILL_Y0,
  input  logic [ROW_W-1:0]  FILL_Y1,
  input  logic [7:0]        FILL_COLOR,
  output logic              FILL_BUSY,
  output logic              FILL_DONE,
  output logic              FILL_ERR,
  output logic              FB_WE,
  output logic [ADDR_W-1:0] FB_WA,
  output logic [7:0]        FB_WD,
  input  logic [7:0]        FB_RD
);

  localparam logic [COL_W-1:0] COL_LIM = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_LIM = ROW_W'(ROWS);

  fb_addr_t   cpu_addr;
  logic       cpu_take;
  logic       cpu_hit;
  logic       cpu_grant;
  logic       fill_grant;
  fb_addr_t   fill_addr;
  logic [7:0] fill_color;

  // A request is taken only while no ack is showing, which also makes the
  // CPU step aside for one cycle after every grant (alternation with fill).
  assign cpu_addr  = fb_addr_t'(CPU_ADDR);
  assign cpu_take  = RST_N && CPU_REQ && !CPU_ACK;
  assign cpu_hit   = in_view(cpu_addr, COL_LIM, ROW_LIM);
  assign cpu_grant = cpu_take && cpu_hit;

  // CPU completion: ack the cycle after acceptance; off-screen reads return 0.
  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      CPU_ACK <= 1'b0;
      CPU_RD  <= 8'h00;
    end else begin
      CPU_ACK <= cpu_take;
      if (cpu_take) begin
        CPU_RD <= cpu_hit ? FB_RD : 8'h00;
      end
    end
  end

`ifdef VGA_FB_FILL_EN
  fb_state_t  state;
  fb_state_t  state_nxt;
  logic       fill_ok;
  logic       fill_load;
  logic       fill_step;
  logic       fill_last;
  logic       done_set;
  logic       err_set;
  logic [7:0] color_q;

  assign fill_ok = (FILL_X0 <= FILL_X1) && (FILL_Y0 <= FILL_Y1) &&
                   (FILL_X1 < COL_LIM) && (FILL_Y1 < ROW_LIM);

  vga_fb_fill_gen u_fill_gen (
    .clk   (CLK_50MHz),
    .rst_n (RST_N),
    .load  (fill_load),
    .step  (fill_step),
    .x0    (FILL_X0),
    .x1    (FILL_X1),
    .y0    (FILL_Y0),
    .y1    (FILL_Y1),
    .addr  (fill_addr),
    .last  (fill_last)
  );

  // Fill state register.
  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and fill-side port request; the CPU has priority in any cycle it is granted.
  always_comb begin
    state_nxt  = state;
    fill_load  = 1'b0;
    fill_step  = 1'b0;
    fill_grant = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (FILL_START) begin
          if (fill_ok) begin
            fill_load = 1'b1;
            state_nxt = FILL;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      FILL: begin
        if (!cpu_grant) begin
          fill_grant = 1'b1;
          fill_step  = 1'b1;
          if (fill_last) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status pulses and the colour captured with the command.
  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      FILL_DONE <= 1'b0;
      FILL_ERR  <= 1'b0;
      color_q   <= 8'h00;
    end else begin
      FILL_DONE <= done_set;
      FILL_ERR  <= err_set;
      if (fill_load) begin
        color_q <= FILL_COLOR;
      end
    end
  end

  assign fill_color = color_q;
  assign FILL_BUSY  = (state == FILL);
`else
  logic unused_fill;
  assign unused_fill = ^{FILL_START, FILL_X0, FILL_X1, FILL_Y0, FILL_Y1, FILL_COLOR};
  assign fill_grant  = 1'b0;
  assign fill_addr   = '0;
  assign fill_color  = 8'h00;
  assign FILL_BUSY   = 1'b0;
  assign FILL_DONE   = 1'b0;
  assign FILL_ERR    = 1'b0;
`endif

  // Port A mux: CPU, fill, or nobody (write enable low).
  always_comb begin
    FB_WE = 1'b0;
    FB_WA = CPU_ADDR;
    FB_WD = CPU_WD;
    if (cpu_grant) begin
      FB_WE = CPU_WE;
    end else if (fill_grant) begin
      FB_WE = 1'b1;
      FB_WA = fill_addr;
      FB_WD = fill_color;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural framebuffer on port A.
// Fill scenarios run when VGA_FB_FILL_EN is defined; otherwise the bench
// checks that the fill inputs have no effect.
module tb_vga_fb_arbiter;

  logic        CLK_50MHz = 1'b0;
  logic        RST_N;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [12:0] CPU_ADDR;
  logic [7:0]  CPU_WD;
  logic [7:0]  CPU_RD;
  logic        CPU_ACK;
  logic        FILL_START;
  logic [6:0]  FILL_X0;
  logic [6:0]  FILL_X1;
  logic [5:0]  FILL_Y0;
  logic [5:0]  FILL_Y1;
  logic [7:0]  FILL_COLOR;
  logic        FILL_BUSY;
  logic        FILL_DONE;
  logic        FILL_ERR;
  logic        FB_WE;
  logic [12:0] FB_WA;
  logic [7:0]  FB_WD;
  logic [7:0]  FB_RD;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem [0:8191];

  always #10 CLK_50MHz = ~CLK_50MHz;

  assign FB_RD = mem[FB_WA];
  always @(posedge CLK_50MHz) if (FB_WE) mem[FB_WA] <= FB_WD;

  vga_fb_arbiter dut (
    .CLK_50MHz  (CLK_50MHz),
    .RST_N      (RST_N),
    .CPU_REQ    (CPU_REQ),
    .CPU_WE     (CPU_WE),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_WD     (CPU_WD),
    .CPU_RD     (CPU_RD),
    .CPU_ACK    (CPU_ACK),
    .FILL_START (FILL_START),
    .FILL_X0    (FILL_X0),
    .FILL_X1    (FILL_X1),
    .FILL_Y0    (FILL_Y0),
    .FILL_Y1    (FILL_Y1),
    .FILL_COLOR (FILL_COLOR),
    .FILL_BUSY  (FILL_BUSY),
    .FILL_DONE  (FILL_DONE),
    .FILL_ERR   (FILL_ERR),
    .FB_WE      (FB_WE),
    .FB_WA      (FB_WA),
    .FB_WD      (FB_WD),
    .FB_RD      (FB_RD)
  );

  // One CPU access; called at a sample point with CPU_ACK low. Returns the
  // port-A view during the request cycle, read data and cycles to ack.
  task automatic cpu_access(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                            output logic we_seen, output logic [12:0] wa_seen,
                            output logic [7:0] wd_seen, output logic [7:0] rd, output int lat);
    CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = addr; CPU_WD = wd;
    #1;
    we_seen = FB_WE; wa_seen = FB_WA; wd_seen = FB_WD;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK_50MHz); #1;
      if (CPU_ACK === 1'b1) begin lat = i; break; end
    end
    rd = CPU_RD;
    CPU_REQ = 1'b0; CPU_WE = 1'b0;
    @(posedge CLK_50MHz); #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WD = '0;
    FILL_START = 1'b0; FILL_X0 = '0; FILL_X1 = '0; FILL_Y0 = '0; FILL_Y1 = '0; FILL_COLOR = '0;
    repeat (3) @(posedge CLK_50MHz);
    #1;
    total++; if (CPU_ACK !== 1'b0) $display("FAIL reset_ack: got %b want 0", CPU_ACK); else passed++;
    total++; if (CPU_RD !== 8'h00) $display("FAIL reset_rd: got %h want 00", CPU_RD); else passed++;
    total++; if (FILL_BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", FILL_BUSY); else passed++;
    total++; if (FILL_DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", FILL_DONE); else passed++;
    total++; if (FILL_ERR !== 1'b0) $display("FAIL reset_err: got %b want 0", FILL_ERR); else passed++;
    total++; if (FB_WE !== 1'b0) $display("FAIL reset_we: got %b want 0", FB_WE); else passed++;
    @(negedge CLK_50MHz); RST_N = 1'b1;
    @(posedge CLK_50MHz); #1;
  endtask

  task automatic test_cpu_write_read;
    logic we_s; logic [12:0] wa_s; logic [7:0] wd_s; logic [7:0] rd; int lat;
    cpu_access(1'b1, 13'h28A, 8'h3C, we_s, wa_s, wd_s, rd, lat);
    total++; if (we_s !== 1'b1) $display("FAIL wr_we: got %b want 1", we_s); else passed++;
    total++; if (wa_s !== 13'h28A) $display("FAIL wr_wa: got %h want 28a", wa_s); else passed++;
    total++; if (wd_s !== 8'h3C) $display("FAIL wr_wd: got %h want 3c", wd_s); else passed++;
    total++; if (lat !== 1) $display("FAIL wr_lat: got %0d want 1", lat); else passed++;
    total++; if (mem[13'h28A] !== 8'h3C) $display("FAIL wr_mem: got %h want 3c", mem[13'h28A]); else passed++;
    cpu_access(1'b0, 13'h28A, 8'h00, we_s, wa_s, wd_s, rd, lat);
    total++; if (we_s !== 1'b0) $display("FAIL rd_we: got %b want 0", we_s); else passed++;
    total++; if (lat !== 1) $display("FAIL rd_lat: got %0d want 1", lat); else passed++;
    total++; if (rd !== 8'h3C) $display("FAIL rd_data: got %h want 3c", rd); else passed++;
    // last visible pixel {59,79}
    cpu_access(1'b1, 13'h1DCF, 8'h5A, we_s, wa_s, wd_s, rd, lat);
    total++; if (we_s !== 1'b1) $display("FAIL edge_we: got %b want 1", we_s); else passed++;
    cpu_access(1'b0, 13'h1DCF, 8'h00, we_s, wa_s, wd_s, rd, lat);
    total++; if (rd !== 8'h5A) $display("FAIL edge_rd: got %h want 5a", rd); else passed++;
  endtask

  task automatic test_cpu_out_of_range;
    logic we_s; logic [12:0] wa_s; logic [7:0] wd_s; logic [7:0] rd; int lat;
    cpu_access(1'b0, 13'h1E00, 8'h00, we_s, wa_s, wd_s, rd, lat);
    total++; if (we_s !== 1'b0) $display("FAIL oor_row_we: got %b want 0", we_s); else passed++;
    total++; if (lat !== 1) $display("FAIL oor_row_lat: got %0d want 1", lat); else passed++;
    total++; if (rd !== 8'h00) $display("FAIL oor_row_rd: got %h want 00", rd); else passed++;
    cpu_access(1'b1, 13'h050, 8'hC3, we_s, wa_s, wd_s, rd, lat);
    total++; if (we_s !== 1'b0) $display("FAIL oor_col_we: got %b want 0", we_s); else passed++;
    total++; if (lat !== 1) $display("FAIL oor_col_lat: got %0d want 1", lat); else passed++;
    total++; if (mem[13'h050] !== 8'h00) $display("FAIL oor_col_mem: got %h want 00", mem[13'h050]); else passed++;
  endtask

`ifdef VGA_FB_FILL_EN
  task automatic test_fill_full;
    int busy_cnt = 0, we_cnt = 0, done_at = -1, first_we = -1, order_err = 0, bad = 0;
    logic [5:0] er = '0;
    logic [6:0] ec = '0;
    FILL_X0 = 7'd0; FILL_X1 = 7'd79; FILL_Y0 = 6'd0; FILL_Y1 = 6'd59; FILL_COLOR = 8'hE0;
    FILL_START = 1'b1;
    for (int k = 1; k <= 4900; k++) begin
      @(posedge CLK_50MHz); #1; FILL_START = 1'b0; #1;
      if (FILL_BUSY === 1'b1) busy_cnt++;
      if (FB_WE === 1'b1) begin
        if (first_we < 0) first_we = k;
        we_cnt++;
        if (FB_WA !== {er, ec} || FB_WD !== 8'hE0) order_err++;
        if (ec == 7'd79) begin ec = '0; er++; end else ec++;
      end
      if (FILL_DONE === 1'b1 && done_at < 0) done_at = k;
      if (done_at > 0 && k > done_at + 1) break;
    end
    for (int a = 0; a < 8192; a++)
      if (a[6:0] < 7'd80 && a[12:7] < 6'd60 && mem[a] !== 8'hE0) bad++;
    total++; if (busy_cnt !== 4800) $display("FAIL full_busy: got %0d want 4800", busy_cnt); else passed++;
    total++; if (we_cnt !== 4800) $display("FAIL full_writes: got %0d want 4800", we_cnt); else passed++;
    total++; if (first_we !== 1) $display("FAIL full_first: got %0d want 1", first_we); else passed++;
    total++; if (done_at !== 4801) $display("FAIL full_done: got %0d want 4801", done_at); else passed++;
    total++; if (order_err !== 0) $display("FAIL full_order: got %0d want 0", order_err); else passed++;
    total++; if (bad !== 0) $display("FAIL full_mem: got %0d bad want 0", bad); else passed++;
    total++; if (mem[13'h050] !== 8'h00) $display("FAIL full_offscreen: got %h want 00", mem[13'h050]); else passed++;
  endtask

  task automatic test_fill_contention;
    logic [12:0] exp_addr [6];
    int fills = 0, own_err = 0, addr_err = 0, done_at = -1;
    logic busy12 = 1'b1, is_cpu, is_fill, exp_cpu;
    exp_addr = '{13'h082, 13'h083, 13'h084, 13'h102, 13'h103, 13'h104};
    FILL_X0 = 7'd2; FILL_X1 = 7'd4; FILL_Y0 = 6'd1; FILL_Y1 = 6'd2; FILL_COLOR = 8'h11;
    FILL_START = 1'b1;
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 13'h104; CPU_WD = 8'h77;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        @(posedge CLK_50MHz); #1; FILL_START = 1'b0;
        if (CPU_ACK === 1'b1) CPU_ADDR = 13'h082;
      end
      #1;
      exp_cpu = (k % 2 == 0);
      is_cpu  = (FB_WE === 1'b1) && (FB_WD === 8'h77);
      is_fill = (FB_WE === 1'b1) && (FB_WD === 8'h11);
      if (is_cpu !== exp_cpu || is_fill !== !exp_cpu) own_err++;
      if (is_fill) begin
        if (fills >= 6 || FB_WA !== exp_addr[fills]) addr_err++;
        fills++;
      end
      if (FILL_DONE === 1'b1 && done_at < 0) done_at = k;
      if (k == 12) busy12 = FILL_BUSY;
    end
    @(posedge CLK_50MHz); #1; CPU_REQ = 1'b0; CPU_WE = 1'b0;
    @(posedge CLK_50MHz); #1;
    total++; if (own_err !== 0) $display("FAIL alt_owner: got %0d bad cycles want 0", own_err); else passed++;
    total++; if (fills !== 6) $display("FAIL alt_fills: got %0d want 6", fills); else passed++;
    total++; if (addr_err !== 0) $display("FAIL alt_order: got %0d want 0", addr_err); else passed++;
    total++; if (done_at !== 12) $display("FAIL alt_done: got %0d want 12", done_at); else passed++;
    total++; if (busy12 !== 1'b0) $display("FAIL alt_busy_end: got %b want 0", busy12); else passed++;
    total++; if (mem[13'h082] !== 8'h77) $display("FAIL alt_cpu_persist: got %h want 77", mem[13'h082]); else passed++;
    total++; if (mem[13'h104] !== 8'h11) $display("FAIL alt_cpu_overwritten: got %h want 11", mem[13'h104]); else passed++;
    total++; if (mem[13'h103] !== 8'h11) $display("FAIL alt_fill_mem: got %h want 11", mem[13'h103]); else passed++;
  endtask

  task automatic test_fill_err_busy;
    logic [6:0] vx0 [3];
    logic [6:0] vx1 [3];
    logic [5:0] vy1 [3];
    int w33 = 0, w44 = 0, w55 = 0, ord_err = 0, done_at = -1, done_cnt = 0;
    logic busy12 = 1'b0, busy20 = 1'b1;
    vx0 = '{7'd10, 7'd0, 7'd0};
    vx1 = '{7'd5, 7'd79, 7'd80};
    vy1 = '{6'd0, 6'd60, 6'd0};
    for (int v = 0; v < 3; v++) begin
      int err_at = -1, err_cnt = 0, we_cnt = 0, busy_cnt = 0;
      FILL_X0 = vx0[v]; FILL_X1 = vx1[v]; FILL_Y0 = 6'd0; FILL_Y1 = vy1[v]; FILL_COLOR = 8'h44;
      FILL_START = 1'b1;
      for (int k = 0; k <= 4; k++) begin
        if (k > 0) begin @(posedge CLK_50MHz); #1; FILL_START = 1'b0; end
        #1;
        if (FB_WE === 1'b1) we_cnt++;
        if (FILL_BUSY === 1'b1) busy_cnt++;
        if (FILL_ERR === 1'b1) begin err_cnt++; if (err_at < 0) err_at = k; end
      end
      total++; if (err_at !== 1 || err_cnt !== 1) $display("FAIL err_pulse%0d: got at %0d count %0d want at 1 count 1", v, err_at, err_cnt); else passed++;
      total++; if (we_cnt !== 0 || busy_cnt !== 0) $display("FAIL err_quiet%0d: got writes %0d busy %0d want 0 0", v, we_cnt, busy_cnt); else passed++;
    end
    // valid 10-pixel fill; a start while busy is ignored, a start in the done cycle is taken
    FILL_X0 = 7'd0; FILL_X1 = 7'd9; FILL_Y0 = 6'd0; FILL_Y1 = 6'd0; FILL_COLOR = 8'h33;
    FILL_START = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        @(posedge CLK_50MHz); #1; FILL_START = 1'b0;
        if (k == 3) begin FILL_START = 1'b1; FILL_X0 = 7'd0; FILL_X1 = 7'd1; FILL_Y0 = 6'd5; FILL_Y1 = 6'd5; FILL_COLOR = 8'h44; end
        if (k == 11) begin FILL_START = 1'b1; FILL_X0 = 7'd0; FILL_X1 = 7'd1; FILL_Y0 = 6'd3; FILL_Y1 = 6'd3; FILL_COLOR = 8'h55; end
      end
      #1;
      if (FB_WE === 1'b1) begin
        if (FB_WD === 8'h33) begin
          if (FB_WA !== 13'(w33)) ord_err++;
          w33++;
        end
        if (FB_WD === 8'h44) w44++;
        if (FB_WD === 8'h55) w55++;
      end
      if (FILL_DONE === 1'b1) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (k == 12) busy12 = FILL_BUSY;
      if (k == 20) busy20 = FILL_BUSY;
    end
    total++; if (w33 !== 10) $display("FAIL busy_writes: got %0d want 10", w33); else passed++;
    total++; if (ord_err !== 0) $display("FAIL busy_order: got %0d want 0", ord_err); else passed++;
    total++; if (w44 !== 0) $display("FAIL busy_ignored: got %0d writes want 0", w44); else passed++;
    total++; if (done_at !== 11) $display("FAIL busy_done: got %0d want 11", done_at); else passed++;
    total++; if (busy12 !== 1'b1) $display("FAIL restart_busy: got %b want 1", busy12); else passed++;
    total++; if (w55 !== 2 || done_cnt !== 2) $display("FAIL restart_fill: got writes %0d dones %0d want 2 2", w55, done_cnt); else passed++;
    total++; if (busy20 !== 1'b0) $display("FAIL restart_idle: got %b want 0", busy20); else passed++;
    total++; if (mem[13'h280] !== 8'hE0) $display("FAIL busy_mem_row5: got %h want e0", mem[13'h280]); else passed++;
    total++; if (mem[13'h181] !== 8'h55) $display("FAIL restart_mem: got %h want 55", mem[13'h181]); else passed++;
    total++; if (mem[13'h00A] !== 8'hE0) $display("FAIL busy_mem_edge: got %h want e0", mem[13'h00A]); else passed++;
  endtask

  task automatic test_fill_reset;
    logic we_s; logic [12:0] wa_s; logic [7:0] wd_s; logic [7:0] rd; int lat;
    int we_cnt = 0, post_we = 0, post_done = 0, post_busy = 0, bad = 0;
    cpu_access(1'b0, 13'h28A, 8'h00, we_s, wa_s, wd_s, rd, lat);
    total++; if (rd !== 8'hE0) $display("FAIL pre_reset_rd: got %h want e0", rd); else passed++;
    FILL_X0 = 7'd0; FILL_X1 = 7'd79; FILL_Y0 = 6'd0; FILL_Y1 = 6'd59; FILL_COLOR = 8'h99;
    FILL_START = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge CLK_50MHz); #1; FILL_START = 1'b0; #1;
      if (FB_WE === 1'b1) we_cnt++;
    end
    @(posedge CLK_50MHz); #1;
    RST_N = 1'b0;
    #1;
    total++; if (we_cnt !== 100) $display("FAIL mid_writes: got %0d want 100", we_cnt); else passed++;
    total++; if (FILL_BUSY !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", FILL_BUSY); else passed++;
    total++; if (FB_WE !== 1'b0) $display("FAIL mid_reset_we: got %b want 0", FB_WE); else passed++;
    total++; if (CPU_RD !== 8'h00) $display("FAIL mid_reset_rd: got %h want 00", CPU_RD); else passed++;
    total++; if (FILL_DONE !== 1'b0 || FILL_ERR !== 1'b0 || CPU_ACK !== 1'b0) $display("FAIL mid_reset_pulses: got done %b err %b ack %b want 0 0 0", FILL_DONE, FILL_ERR, CPU_ACK); else passed++;
    repeat (2) @(posedge CLK_50MHz);
    @(negedge CLK_50MHz); RST_N = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge CLK_50MHz); #1;
      if (FB_WE === 1'b1) post_we++;
      if (FILL_DONE === 1'b1) post_done++;
      if (FILL_BUSY === 1'b1) post_busy++;
    end
    for (int a = 0; a < 100; a++)
      if (mem[{6'(a / 80), 7'(a % 80)}] !== 8'h99) bad++;
    total++; if (post_we !== 0 || post_busy !== 0) $display("FAIL no_resume: got writes %0d busy %0d want 0 0", post_we, post_busy); else passed++;
    total++; if (post_done !== 0) $display("FAIL no_done: got %0d want 0", post_done); else passed++;
    total++; if (bad !== 0) $display("FAIL kept_pixels: got %0d bad want 0", bad); else passed++;
    total++; if (mem[13'h094] !== 8'hE0) $display("FAIL unwritten_pixel: got %h want e0", mem[13'h094]); else passed++;
  endtask
`else
  task automatic test_fill_disabled;
    logic we_s; logic [12:0] wa_s; logic [7:0] wd_s; logic [7:0] rd; int lat;
    int we_cnt = 0, stat_cnt = 0;
    FILL_X0 = 7'd0; FILL_X1 = 7'd3; FILL_Y0 = 6'd0; FILL_Y1 = 6'd0; FILL_COLOR = 8'hAA;
    FILL_START = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK_50MHz); #1;
      if (FB_WE === 1'b1) we_cnt++;
      if (FILL_BUSY !== 1'b0 || FILL_DONE !== 1'b0 || FILL_ERR !== 1'b0) stat_cnt++;
    end
    total++; if (we_cnt !== 0) $display("FAIL dis_writes: got %0d want 0", we_cnt); else passed++;
    total++; if (stat_cnt !== 0) $display("FAIL dis_status: got %0d want 0", stat_cnt); else passed++;
    cpu_access(1'b1, 13'h001, 8'h21, we_s, wa_s, wd_s, rd, lat);
    total++; if (we_s !== 1'b1 || lat !== 1) $display("FAIL dis_cpu: got we %b lat %0d want 1 1", we_s, lat); else passed++;
    FILL_START = 1'b0;
    total++; if (mem[13'h000] !== 8'h00 || mem[13'h001] !== 8'h21) $display("FAIL dis_mem: got %h %h want 00 21", mem[13'h000], mem[13'h001]); else passed++;
  endtask
`endif

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
    test_reset;
    test_cpu_write_read;
    test_cpu_out_of_range;
`ifdef VGA_FB_FILL_EN
    test_fill_full;
    test_fill_contention;
    test_fill_err_busy;
    test_fill_reset;
`else
    test_fill_disabled;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter COLS, default 80, visible columns per row; the column field is always 7 bits.
REQ-002 Parameter ROWS, default 60, visible rows; the row field is always 6 bits.
REQ-003 CLK_50MHz  in  1  sole clock, all state updates on the rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 CPU_REQ  in  1  access request, level, held with stable fields until CPU_ACK.
REQ-006 CPU_WE  in  1  1=write, 0=read.
REQ-007 CPU_ADDR  in  13  pixel address {row[5:0], col[6:0]}.
REQ-008 CPU_WD  in  8  write colour.
REQ-009 CPU_RD  out  8  registered read data, valid while CPU_ACK=1.
REQ-010 CPU_ACK  out  1  one-cycle completion pulse.
REQ-011 FILL_START  in  1  rectangle-fill command pulse.
REQ-012 FILL_X0/FILL_X1  in  7 each  inclusive column bounds.
REQ-013 FILL_Y0/FILL_Y1  in  6 each  inclusive row bounds.
REQ-014 FILL_COLOR  in  8  fill colour.
REQ-015 FILL_BUSY  out  1  fill in progress; FILL_DONE / FILL_ERR  out  1 each  one-cycle pulses.
REQ-016 FB_WE  out  1, FB_WA  out  13, FB_WD  out  8  framebuffer port A; FB_RD  in  8  combinational read of FB_WA.

Function
REQ-017 FSM states IDLE, FILL; port A owned each cycle by exactly one of CPU, FILL or none; FB_WE=0 when none.
REQ-018 CPU granted in a cycle when CPU_REQ=1 and CPU_ACK=0; FB_WA=CPU_ADDR, FB_WE=CPU_WE, FB_WD=CPU_WD; CPU_ACK=1 and CPU_RD=FB_RD registered at that edge (latency 1, max one CPU access per 2 cycles).
REQ-019 CPU address with col>=COLS or row>=ROWS: no grant of port A, FB_WE=0, CPU_RD=0, CPU_ACK still pulses after 1 cycle.
REQ-020 FILL_START sampled in IDLE only; ignored in FILL. Bounds, colour latched at the start edge.
REQ-021 Invalid fill (X0>X1, Y0>Y1, X1>=COLS, Y1>=ROWS): FILL_ERR pulses next cycle, no writes, stay IDLE.
REQ-022 Valid fill: FILL_BUSY=1 from next cycle; one pixel written per fill-owned cycle, row-major, X0..X1 then Y+1, col wraps to X0.
REQ-023 Arbitration: CPU wins if the previous cycle was not a CPU grant; else FILL wins (strict alternation under contention).
REQ-024 Cycle after the last pixel (X1,Y1) is written: FILL_DONE=1, FILL_BUSY=0, state IDLE; FILL_START in that cycle is accepted.
REQ-025 CPU write to a pixel not yet filled is overwritten by the fill; to an already-filled pixel it persists.

Reset
REQ-026 RST_N low asynchronously forces IDLE, CPU_ACK=0, CPU_RD=0, FILL_BUSY=0, FILL_DONE=0, FILL_ERR=0, FB_WE=0; fill-address counters cleared.
REQ-027 Reset mid-fill aborts it; no FILL_DONE is issued; written pixels remain in memory.

Configuration
REQ-028 Macro VGA_FB_FILL_EN defined: fill engine present per REQ-020..027.
REQ-029 Macro VGA_FB_FILL_EN undefined: FILL_* inputs ignored, FILL_BUSY/DONE/ERR tied 0, CPU never loses arbitration; ports unchanged.

Structure
REQ-030 Package vga_fb_pkg holds COL_W=7, ROW_W=6, ADDR_W=13, struct fb_addr_t {row, col}, and enum fb_state_t {IDLE, FILL}.
REQ-031 Sub-module vga_fb_fill_gen holds the fill row/col counters and wrap/last detection; instantiated only under VGA_FB_FILL_EN.

Verification
REQ-032 CPU write addr {5,10}=0x28A, data 0x3C, then read it -> each ACK after 1 cycle; read returns CPU_RD=0x3C.
REQ-033 CPU read addr {60,0} -> FB_WE=0, CPU_ACK after 1 cycle, CPU_RD=0x00.
REQ-034 Fill (0,0)-(79,59) colour 0xE0, no CPU traffic -> 4800 consecutive writes, FILL_BUSY 4800 cycles, FILL_DONE in cycle 4801, all cells read 0xE0.
REQ-035 Fill (2,1)-(4,2), CPU_REQ held continuously -> CPU/FILL grants alternate; 6 fill writes in order 0x82,0x83,0x84,0x102,0x103,0x104.
REQ-036 Fill X0=10, X1=5 -> FILL_ERR pulse next cycle, no FB_WE; FILL_START while busy -> ignored.
REQ-037 Assert RST_N low after 100 fill writes -> outputs at reset values at once, no FILL_DONE, fill not resumed after release.
